// File: rtl/fifo_fwft_reader_pkg.sv
// Shared sizing constants and pointer helper for the FWFT reader and its local store.
package fifo_fwft_reader_pkg;

    localparam int FWFT_DEPTH = 3;
    localparam int FWFT_PTR_W = 2;
    localparam int FWFT_CNT_W = 2;

    localparam logic [FWFT_PTR_W-1:0] FWFT_LAST_PTR = FWFT_PTR_W'(FWFT_DEPTH - 1);
    localparam logic [FWFT_CNT_W-1:0] FWFT_FULL_CNT = FWFT_CNT_W'(FWFT_DEPTH);

    // Circular pointer step; the store has three entries, so 2 wraps back to 0.
    function automatic logic [FWFT_PTR_W-1:0] ptr_next(input logic [FWFT_PTR_W-1:0] ptr);
        return (ptr == FWFT_LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

endpackage

// File: rtl/fwft_skid_store.sv
// Three-entry circular buffer holding words read from the FIFO until downstream takes them.
module fwft_skid_store
    import fifo_fwft_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_data
);

    logic [DATA_WIDTH-1:0] store_q [FWFT_DEPTH];
    logic [DATA_WIDTH-1:0] store_d [FWFT_DEPTH];
    logic [FWFT_PTR_W-1:0] head_q;
    logic [FWFT_PTR_W-1:0] head_d;
    logic [FWFT_PTR_W-1:0] tail_q;
    logic [FWFT_PTR_W-1:0] tail_d;

    // Push and pop are independent; the owner guarantees no push into a full store.
    always_comb begin
        store_d = store_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (i_push) begin
            store_d[tail_q] = i_push_data;
            tail_d          = ptr_next(tail_q);
        end
        if (i_pop) begin
            head_d = ptr_next(head_q);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            for (int i = 0; i < FWFT_DEPTH; i++) begin
                store_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
        end else begin
            store_q <= store_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    assign o_head_data = store_q[head_q];

endmodule

// File: rtl/fifo_fwft_reader.sv
// Converts a standard-mode FIFO read port into a first-word-fall-through valid/ready stream.
module fifo_fwft_reader
    import fifo_fwft_reader_pkg::*;
#(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_empty,
    output logic                  o_rd,
    input  logic [DATA_WIDTH-1:0] i_rdata,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic [1:0]            o_level
);

    logic [FWFT_CNT_W-1:0] occ_q;
    logic [FWFT_CNT_W-1:0] occ_d;
    logic                  inflight_q;
    logic                  inflight_d;
    logic [FWFT_CNT_W-1:0] credit_used;
    logic                  pop;

    // A read is only issued when a store slot is guaranteed for it, counting the word
    // still in flight, so i_ready never reaches o_rd combinationally.
    always_comb begin
        credit_used = occ_q + {1'b0, inflight_q};
        o_valid     = (occ_q != '0);
        pop         = o_valid && i_ready;
        o_rd        = !i_rst && !i_empty && (credit_used < FWFT_FULL_CNT);
        inflight_d  = o_rd;
        occ_d       = occ_q + {1'b0, inflight_q} - {1'b0, pop};
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
        end
    end

    fwft_skid_store #(
        .DATA_WIDTH(DATA_WIDTH)
    ) u_store (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_push      (inflight_q),
        .i_push_data (i_rdata),
        .i_pop       (pop),
        .o_head_data (o_data)
    );

    assign o_level = occ_q;

endmodule
